// File: rtl/gigatron_alu_dest_regs.sv
// Gigatron destination register stage.
// Takes the 8-bit result of the cascaded x74xx283 adders and writes it into
// AC, X, Y or OUT on each CPU cycle strobe. X also has an auto-increment.
// XOUT is loaded from AC when the hSync bit of OUT rises. Every output is a
// flop, so the bus mux, RAM address and video stages see stable values.
module gigatron_alu_dest_regs #(
    parameter int               WIDTH     = 8,
    parameter int               HSYNC_BIT = 6,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             clock_50,
    input  logic             reset_n,
    input  logic             cycle_en,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout,
    input  logic             load_en,
    input  logic [1:0]       dest_sel,
    input  logic             x_inc,
    output logic [WIDTH-1:0] ac,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] out_reg,
    output logic [WIDTH-1:0] xout,
    output logic             cout_q,
    output logic             hsync_rise
);

    typedef enum logic [1:0] {
        DEST_AC  = 2'b00,
        DEST_X   = 2'b01,
        DEST_Y   = 2'b10,
        DEST_OUT = 2'b11
    } dest_e;

    dest_e dest;
    logic  load_any;
    logic  load_ac;
    logic  load_x;
    logic  load_y;
    logic  load_out;
    logic  inc_x;
    logic  hsync_prev;
    logic  hsync_edge;

    // Decode the write enables and the hSync rising edge for this cycle.
    // NOTE: every signal gets a default first, so no path through this block
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        dest       = dest_e'(dest_sel);
        load_any   = 1'b0;
        load_ac    = 1'b0;
        load_x     = 1'b0;
        load_y     = 1'b0;
        load_out   = 1'b0;
        inc_x      = 1'b0;
        hsync_edge = 1'b0;
        if (cycle_en) begin
            load_any   = load_en;
            load_ac    = load_en && (dest == DEST_AC);
            load_x     = load_en && (dest == DEST_X);
            load_y     = load_en && (dest == DEST_Y);
            load_out   = load_en && (dest == DEST_OUT);
            // A load into X takes precedence over the increment.
            inc_x      = x_inc && !load_x;
            // Compare against the OUT value from before this cycle's write.
            hsync_edge = out_reg[HSYNC_BIT] && !hsync_prev;
        end
    end

    // AC, Y and OUT registers: load the ALU result into the selected register.
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, which keeps the evaluation order of blocks irrelevant.
    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            ac      <= RST_VAL;
            y       <= RST_VAL;
            out_reg <= RST_VAL;
        end else begin
            if (load_ac)  ac      <= alu_sum;
            if (load_y)   y       <= alu_sum;
            if (load_out) out_reg <= alu_sum;
        end
    end

    // X register: load, or else increment with wrap-around (no carry out).
    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            x <= RST_VAL;
        end else if (load_x) begin
            x <= alu_sum;
        end else if (inc_x) begin
            x <= x + WIDTH'(1);
        end
    end

    // Carry flop: follows alu_cout on any load and holds otherwise.
    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            cout_q <= 1'b0;
        end else if (load_any) begin
            cout_q <= alu_cout;
        end
    end

    // hSync tracking: remember the last level, latch AC into XOUT on a rise.
    // XOUT takes AC as it was before this cycle, so an AC write in the same
    // cycle does not leak into XOUT.
    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            hsync_prev <= 1'b0;
            xout       <= RST_VAL;
            hsync_rise <= 1'b0;
        end else begin
            if (cycle_en)   hsync_prev <= out_reg[HSYNC_BIT];
            if (hsync_edge) xout       <= ac;
            hsync_rise <= hsync_edge;
        end
    end

endmodule

// File: tb/tb_gigatron_alu_dest_regs.sv
// Scoreboard bench for gigatron_alu_dest_regs.
// The stimulus side drives one clock of inputs, advances a register-file
// model, and queues the state expected after the next rising edge. A monitor
// pops one expectation per clock and compares it with the DUT outputs.
module tb_gigatron_alu_dest_regs;

    logic       clock_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       cycle_en = 1'b0;
    logic [7:0] alu_sum  = '0;
    logic       alu_cout = 1'b0;
    logic       load_en  = 1'b0;
    logic [1:0] dest_sel = '0;
    logic       x_inc    = 1'b0;
    logic [7:0] ac, x, y, out_reg, xout;
    logic       cout_q, hsync_rise;

    gigatron_alu_dest_regs #(.WIDTH(8), .HSYNC_BIT(6), .RST_VAL(8'h00)) dut (
        .clock_50   (clock_50),
        .reset_n    (reset_n),
        .cycle_en   (cycle_en),
        .alu_sum    (alu_sum),
        .alu_cout   (alu_cout),
        .load_en    (load_en),
        .dest_sel   (dest_sel),
        .x_inc      (x_inc),
        .ac         (ac),
        .x          (x),
        .y          (y),
        .out_reg    (out_reg),
        .xout       (xout),
        .cout_q     (cout_q),
        .hsync_rise (hsync_rise)
    );

    always #5 clock_50 = ~clock_50;

    typedef struct packed {
        logic [7:0] ac;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] out_reg;
        logic [7:0] xout;
        logic       cout_q;
        logic       hsync_rise;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    // Reference model: a 4-entry register file indexed by dest_sel
    // (0=AC 1=X 2=Y 3=OUT), plus XOUT, carry, last seen hSync level, pulse.
    logic [7:0] regs [4];
    logic [7:0] m_xout  = '0;
    logic       m_cout  = 1'b0;
    logic       m_level = 1'b0;
    logic       m_rise  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one clock of inputs, advance the model, queue the expected state.
    task automatic cyc(input logic rst, input logic en, input logic ld, input logic [1:0] sel,
                       input logic [7:0] sum, input logic co, input logic inc);
        logic       level_now;
        logic [7:0] ac_before;
        snap_t      s;
        @(negedge clock_50);
        reset_n  = rst;
        cycle_en = en;
        load_en  = ld;
        dest_sel = sel;
        alu_sum  = sum;
        alu_cout = co;
        x_inc    = inc;
        if (!rst) begin
            foreach (regs[i]) regs[i] = 8'h00;
            m_xout  = 8'h00;
            m_cout  = 1'b0;
            m_level = 1'b0;
            m_rise  = 1'b0;
        end else if (!en) begin
            m_rise = 1'b0;
        end else begin
            level_now = regs[3][6];
            ac_before = regs[0];
            m_rise    = level_now && !m_level;
            if (m_rise) m_xout = ac_before;
            m_level = level_now;
            if (ld) begin
                regs[sel] = sum;
                m_cout    = co;
            end
            if (inc && !(ld && sel == 2'd1)) regs[1] = regs[1] + 8'd1;
        end
        s.ac         = regs[0];
        s.x          = regs[1];
        s.y          = regs[2];
        s.out_reg    = regs[3];
        s.xout       = m_xout;
        s.cout_q     = m_cout;
        s.hsync_rise = m_rise;
        exp_q.push_back(s);
    endtask

    // Clocks with cycle_en low and random data on the other inputs.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0, 1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Wait until the last driven clock edge has taken effect.
    task automatic settle();
        @(posedge clock_50);
        #2;
    endtask

    // Monitor: one expected snapshot per clock edge, compared 1 time unit later.
    initial begin
        snap_t e;
        forever begin
            @(posedge clock_50);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_ac",         ac,         e.ac);
                check("sb_x",          x,          e.x);
                check("sb_y",          y,          e.y);
                check("sb_out_reg",    out_reg,    e.out_reg);
                check("sb_xout",       xout,       e.xout);
                check("sb_cout_q",     cout_q,     e.cout_q);
                check("sb_hsync_rise", hsync_rise, e.hsync_rise);
            end
        end
    end

    initial begin
        foreach (regs[i]) regs[i] = 8'h00;

        // Power-on reset.
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);

        // 1: arbitrary loads, then two reset clocks with active strobes.
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 1'b1, 1'b1, 2'(i), 8'($urandom_range(1, 255)) | 8'h40, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 8'hAA, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 2'd3, 8'h55, 1'b1, 1'b1);
        settle();
        check("rst_ac", ac, 8'h00);
        check("rst_x", x, 8'h00);
        check("rst_y", y, 8'h00);
        check("rst_out_reg", out_reg, 8'h00);
        check("rst_xout", xout, 8'h00);
        check("rst_cout_q", cout_q, 1'b0);
        check("rst_hsync_rise", hsync_rise, 1'b0);

        // 2: load AC with carry, then hold while cycle_en is low.
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 8'hFE, 1'b1, 1'b0);
        settle();
        check("load_ac", ac, 8'hFE);
        check("load_cout", cout_q, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'h12, 1'b0, 1'b0);
        settle();
        check("hold_ac", ac, 8'hFE);
        check("hold_cout", cout_q, 1'b1);

        // 3: X wrap on increment, then load beats increment.
        cyc(1'b1, 1'b1, 1'b1, 2'd1, 8'hFF, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'h77, 1'b1, 1'b1);
        settle();
        check("x_wrap", x, 8'h00);
        check("x_wrap_cout_hold", cout_q, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd1, 8'h10, 1'b0, 1'b1);
        settle();
        check("x_load_wins", x, 8'h10);

        // 4: hSync rise latches AC one CPU cycle after the OUT write.
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 8'h5A, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd3, 8'h40, 1'b0, 1'b0);
        settle();
        check("no_rise_on_write", hsync_rise, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        settle();
        check("rise_xout", xout, 8'h5A);
        check("rise_pulse", hsync_rise, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        settle();
        check("rise_pulse_end", hsync_rise, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd3, 8'h40, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        settle();
        check("steady_xout", xout, 8'h5A);
        check("steady_no_pulse", hsync_rise, 1'b0);

        // 5: rise cycle with an AC write in the same cycle.
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 8'h5A, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd3, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd3, 8'h40, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 8'h33, 1'b0, 1'b0);
        settle();
        check("same_cycle_xout", xout, 8'h5A);
        check("same_cycle_ac", ac, 8'h33);
        check("same_cycle_pulse", hsync_rise, 1'b1);

        // 6: 256 strobed increments from x=0 return to 0; Y never increments.
        cyc(1'b1, 1'b1, 1'b1, 2'd2, 8'hA5, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'd1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 2'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            idle(7);
        end
        settle();
        check("inc256_x", x, 8'h00);
        check("inc256_y", y, 8'hA5);
        check("inc256_ac", ac, 8'h33);
        check("inc256_out_reg", out_reg, 8'h40);

        // Random traffic against the model, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        // Let the monitor drain the queue within a bounded number of clocks.
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clock_50);
        #2;
        check("queue_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
